counter_seq: RTL and testbench
==============================

# counter_seq

Command-driven sequencer that sits directly upstream of the `counter` block and generates its `enable`, `preload`, `preload_data` and `mode` inputs. It accepts LOAD / UP / DOWN / PAUSE commands over a valid/ready handshake and runs each one for a programmed number of cycles. It observes the counter's `detect` output and reports the number of wrap events seen during each command. It lets testbenches and higher-level control drive the counter with bounded, repeatable bursts instead of raw per-cycle strobes.

## Interface
- `WIDTH`, default 4: counter data width; must match the downstream counter.
- `LEN_W`, default 8: width of the command length field and of `wrap_count`.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command; high only in IDLE.
- `cmd_op`  in  2  00 LOAD, 01 UP, 10 DOWN, 11 PAUSE.
- `cmd_arg`  in  WIDTH  preload value; used by LOAD only.
- `cmd_len`  in  LEN_W  number of cycles to run; used by UP, DOWN and PAUSE.
- `cnt_enable`  out  1  drives counter `enable`.
- `cnt_preload`  out  1  drives counter `preload`.
- `cnt_preload_data`  out  WIDTH  drives counter `preload_data`.
- `cnt_mode`  out  1  drives counter `mode`; 0 = up, 1 = down.
- `cnt_detect`  in  1  counter `detect` (registered in the counter, lags the counting edge by one cycle).
- `busy`  out  1  a command is in progress (any state other than IDLE).
- `done`  out  1  single-cycle pulse at command completion.
- `wrap_count`  out  LEN_W  number of `cnt_detect` pulses seen during the last command; holds its value until the next command is accepted.

## Operation
- States: IDLE, LOAD, RUN, PAUSE, DRAIN.
- IDLE: `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`, the sequencer latches op, arg and len, clears `wrap_count` and moves to the state for the op. LEN_W-bit down-counter `remaining` is loaded with `cmd_len`.
- LOAD: one cycle with `cnt_enable`=1, `cnt_preload`=1, `cnt_preload_data`=arg. Next state is DRAIN; len is ignored.
- RUN (UP/DOWN): `cnt_enable`=1 and `cnt_preload`=0. `cnt_mode`=1 for DOWN and 0 for UP. The sequencer stays in RUN for exactly len cycles, then moves to DRAIN.
- PAUSE: all counter controls are 0 for len cycles, then the sequencer moves to DRAIN.
- len = 0 for UP/DOWN/PAUSE: the command goes straight to DRAIN with no enable cycles.
- DRAIN: one cycle with controls 0, so the detect pulse from the final counting edge can be sampled. Next state is IDLE, and `done` pulses in that first IDLE cycle.
- `wrap_count` increments by 1 on each edge where the state is RUN or DRAIN and `cnt_detect`=1. It cannot exceed len, so no saturation logic is needed.
- Outside LOAD: `cnt_preload_data`=0 and `cnt_preload`=0. `cnt_mode` is 0 outside DOWN RUN.
- All outputs are registered (driven from state flops); there are no combinational input-to-output paths except `cmd_ready`, which is decoded from the state.

## Timing
- Command accepted at edge k. Controls for the first active cycle are valid in cycle k+1.
- UP/DOWN with len=N: `cnt_enable` is high in cycles k+1..k+N. DRAIN is cycle k+N+1. `done` and `cmd_ready` are high in cycle k+N+2. Total latency from acceptance to done is N+2.
- LOAD: preload cycle k+1, DRAIN k+2, `done` k+3.
- Back-to-back: a command presented in the `done` cycle is accepted at the end of that cycle, so there is no bubble beyond DRAIN.
- Reset, asynchronous at any time (mid-RUN included): state goes to IDLE immediately, and `cnt_enable`, `cnt_preload`, `cnt_mode`, `cnt_preload_data`, `busy`, `done`, `wrap_count` all go to 0. `cmd_ready`=1 once reset deasserts. An aborted command produces no `done`.

## Configuration
- `COUNTER_SEQ_ABORT_EN` defined: adds input `cmd_abort` (1 bit).
  - If `cmd_abort` is sampled high in RUN or PAUSE, that cycle is the last active cycle and the sequencer moves to DRAIN.
  - `done` pulses normally, and `wrap_count` reflects only the cycles actually run.
  - `cmd_abort` is ignored in IDLE, LOAD and DRAIN.
- `COUNTER_SEQ_ABORT_EN` not defined: the port is absent and every command always runs for its full len.

## Test plan
- LOAD arg=4'hE -> one cycle with preload=1 and data=E. Counter result=E. `done` 3 cycles after acceptance, `wrap_count`=0.
- After LOAD E, UP len=3 -> enable for 3 cycles, result E→F→0→1. `wrap_count`=1. `done` in cycle k+5.
- With result=1, DOWN len=2 -> `cnt_mode`=1 for 2 cycles, result 1→0→F. `wrap_count`=0.
- PAUSE len=4, then UP len=0 with `cmd_valid` held high -> no enable for 4 cycles. Second command is accepted in the `done` cycle and completes 2 cycles later with `wrap_count`=0.
- Reset asserted mid-way through UP len=20 -> all outputs 0 immediately, no `done`. A new LOAD is accepted in the first cycle after reset deasserts.
- `COUNTER_SEQ_ABORT_EN` defined: UP len=10 with abort in the 4th RUN cycle -> exactly 4 enable cycles, then DRAIN, then `done`.

Source files
------------

// File: rtl/counter_seq.sv
// Command-driven sequencer generating enable/preload/mode strobes for the downstream counter.
// Optional build macro COUNTER_SEQ_ABORT_EN adds cmd_abort to cut RUN/PAUSE short.
module counter_seq #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [LEN_W-1:0] cmd_len,
`ifdef COUNTER_SEQ_ABORT_EN
  input  logic             cmd_abort,
`endif
  output logic             cnt_enable,
  output logic             cnt_preload,
  output logic [WIDTH-1:0] cnt_preload_data,
  output logic             cnt_mode,
  input  logic             cnt_detect,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] wrap_count
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_PAUSE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PAUSE,
    DRAIN
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] next_remaining;
  logic             down_q;
  logic             next_down;
  logic             accept;
  logic             abort_req;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

`ifdef COUNTER_SEQ_ABORT_EN
  assign abort_req = cmd_abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    next_state     = state;
    next_remaining = remaining;
    next_down      = down_q;
    case (state)
      IDLE: begin
        if (accept) begin
          next_remaining = cmd_len;
          next_down      = (cmd_op == OP_DOWN);
          case (cmd_op)
            OP_LOAD:  next_state = LOAD;
            OP_PAUSE: next_state = (cmd_len == '0) ? DRAIN : PAUSE;
            default:  next_state = (cmd_len == '0) ? DRAIN : RUN;
          endcase
        end
      end
      LOAD: next_state = DRAIN;
      RUN, PAUSE: begin
        // remaining counts the current cycle, so 1 means this is the last active cycle
        next_remaining = remaining - 1'b1;
        if ((remaining <= LEN_W'(1)) || abort_req) begin
          next_state = DRAIN;
        end
      end
      DRAIN:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      down_q    <= 1'b0;
    end else begin
      state     <= next_state;
      remaining <= next_remaining;
      down_q    <= next_down;
    end
  end

  // Counter controls are registered from the upcoming state so they align with it cycle for cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_enable       <= 1'b0;
      cnt_preload      <= 1'b0;
      cnt_preload_data <= '0;
      cnt_mode         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      cnt_enable       <= (next_state == RUN) || (next_state == LOAD);
      cnt_preload      <= (next_state == LOAD);
      cnt_preload_data <= (next_state == LOAD) ? cmd_arg : '0;
      cnt_mode         <= (next_state == RUN) && next_down;
      busy             <= (next_state != IDLE);
      done             <= (state == DRAIN);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_count <= '0;
    end else if (accept) begin
      wrap_count <= '0;
    end else if (((state == RUN) || (state == DRAIN)) && cnt_detect) begin
      wrap_count <= wrap_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_counter_seq.sv
// Directed bench for counter_seq with a behavioural counter model closing the detect loop.
// Abort scenario is compiled in only when COUNTER_SEQ_ABORT_EN is defined.
module tb_counter_seq;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_PAUSE = 2'b11;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic [7:0] cmd_len;
`ifdef COUNTER_SEQ_ABORT_EN
  logic       cmd_abort;
`endif
  logic       cnt_enable;
  logic       cnt_preload;
  logic [3:0] cnt_preload_data;
  logic       cnt_mode;
  logic       cnt_detect;
  logic       busy;
  logic       done;
  logic [7:0] wrap_count;

  logic [3:0] count;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] arg;
    int         active;
    int         abort_at;
    logic [7:0] wrap;
    logic [3:0] count;
  } exp_t;

  exp_t sb[$];

  counter_seq #(.WIDTH(4), .LEN_W(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_arg          (cmd_arg),
    .cmd_len          (cmd_len),
`ifdef COUNTER_SEQ_ABORT_EN
    .cmd_abort        (cmd_abort),
`endif
    .cnt_enable       (cnt_enable),
    .cnt_preload      (cnt_preload),
    .cnt_preload_data (cnt_preload_data),
    .cnt_mode         (cnt_mode),
    .cnt_detect       (cnt_detect),
    .busy             (busy),
    .done             (done),
    .wrap_count       (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter stand-in: detect flags an up-count overflow, one cycle after the wrapping edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= 4'h0;
      cnt_detect <= 1'b0;
    end else begin
      cnt_detect <= cnt_enable && !cnt_preload && !cnt_mode && (count == 4'hF);
      if (cnt_enable) begin
        count <= cnt_preload ? cnt_preload_data : (cnt_mode ? count - 4'h1 : count + 4'h1);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] arg, input logic [7:0] len,
                               input logic [7:0] exp_wrap, input logic [3:0] exp_count, input int abort_at);
    exp_t e;
    checkOutput("ready_before_cmd", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_arg    = arg;
    cmd_len    = len;
    e.op       = op;
    e.arg      = arg;
    e.abort_at = abort_at;
    e.active   = (op == OP_LOAD) ? 1 : ((abort_at != 0) ? abort_at : int'(len));
    e.wrap     = exp_wrap;
    e.count    = exp_count;
    sb.push_back(e);
  endtask

  // Walks one command cycle by cycle from acceptance to its done pulse
  task automatic followCommand(input logic hold);
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: observed 0 entries required 1");
      return;
    end
    e = sb[0];
    @(posedge clk);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    for (int i = 1; i <= e.active; i++) begin
      checkOutput("active_enable", cnt_enable, (e.op != OP_PAUSE));
      checkOutput("active_preload", cnt_preload, (e.op == OP_LOAD));
      checkOutput("active_data", cnt_preload_data, (e.op == OP_LOAD) ? e.arg : 4'h0);
      checkOutput("active_mode", cnt_mode, (e.op == OP_DOWN));
      checkOutput("active_busy", busy, 1);
      checkOutput("active_ready", cmd_ready, 0);
      checkOutput("active_done", done, 0);
`ifdef COUNTER_SEQ_ABORT_EN
      cmd_abort = (e.abort_at == i);
`endif
      @(negedge clk);
    end
`ifdef COUNTER_SEQ_ABORT_EN
    cmd_abort = 1'b0;
`endif
    checkOutput("drain_enable", cnt_enable, 0);
    checkOutput("drain_preload", cnt_preload, 0);
    checkOutput("drain_mode", cnt_mode, 0);
    checkOutput("drain_busy", busy, 1);
    checkOutput("drain_done", done, 0);
    @(negedge clk);
    e = sb.pop_front();
    checkOutput("done_pulse", done, 1);
    checkOutput("done_ready", cmd_ready, 1);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_enable", cnt_enable, 0);
    checkOutput("wrap_count", wrap_count, e.wrap);
    checkOutput("counter_value", count, e.count);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_arg   = 4'h0;
    cmd_len   = 8'h0;
`ifdef COUNTER_SEQ_ABORT_EN
    cmd_abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset_enable", cnt_enable, 0);
    checkOutput("reset_preload", cnt_preload, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_wrap", wrap_count, 0);
    reset = 1'b0;
    #1;
    checkOutput("ready_after_reset", cmd_ready, 1);

    applyStimulus(OP_LOAD, 4'hE, 8'd7, 8'd0, 4'hE, 0);
    followCommand(1'b0);
    applyStimulus(OP_UP, 4'h5, 8'd3, 8'd1, 4'h1, 0);
    followCommand(1'b0);
    applyStimulus(OP_DOWN, 4'h9, 8'd2, 8'd0, 4'hF, 0);
    followCommand(1'b0);
    applyStimulus(OP_PAUSE, 4'h3, 8'd4, 8'd0, 4'hF, 0);
    followCommand(1'b1);
    applyStimulus(OP_UP, 4'h0, 8'd0, 8'd0, 4'hF, 0);
    followCommand(1'b0);
    // Overflow on the final counting edge is only visible during DRAIN
    applyStimulus(OP_UP, 4'h0, 8'd1, 8'd1, 4'h0, 0);
    followCommand(1'b0);

    applyStimulus(OP_UP, 4'h5, 8'd20, 8'd0, 4'h0, 0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid_run_enable", cnt_enable, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_reset_enable", cnt_enable, 0);
    checkOutput("abort_reset_preload", cnt_preload, 0);
    checkOutput("abort_reset_mode", cnt_mode, 0);
    checkOutput("abort_reset_data", cnt_preload_data, 0);
    checkOutput("abort_reset_busy", busy, 0);
    checkOutput("abort_reset_done", done, 0);
    checkOutput("abort_reset_wrap", wrap_count, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    checkOutput("post_reset_ready", cmd_ready, 1);
    checkOutput("post_reset_done", done, 0);
    applyStimulus(OP_LOAD, 4'h3, 8'd0, 8'd0, 4'h3, 0);
    followCommand(1'b0);
    applyStimulus(OP_UP, 4'hA, 8'd1, 8'd0, 4'h4, 0);
    followCommand(1'b0);

`ifdef COUNTER_SEQ_ABORT_EN
    applyStimulus(OP_UP, 4'h0, 8'd10, 8'd0, 4'h8, 4);
    followCommand(1'b0);
`endif

    @(negedge clk);
    checkOutput("idle_done_low", done, 0);
    checkOutput("idle_busy_low", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
